// File: rtl/sha_mem_arbiter.sv
// sha_mem_arbiter
//   Shares one synchronous memory port among NUM_CORES SHA-256 cores.
//   A requesting core gets a registered one-hot grant and owns the port
//   for a burst of beats (beat = cycle with grant & request). Ownership
//   rotates round-robin, and a burst is capped at MAX_BURST beats.
//   Read data returns one cycle after the read beat with a per-core strobe.
//
// Optional feature: define SHA_ARB_FIXED_PRIO_EN to make arbitration always
//   search from core 0 (lowest requesting index wins). The default build
//   uses round-robin search starting at owner+1.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   core_req/last/we      per-core request, last-beat marker, write flag
//   core_addr/core_wdata  packed per-core address / write data
//   core_gnt              registered one-hot grant
//   core_rvalid           per-core read-data strobe (beat + 1 cycle)
//   core_rdata            broadcast of mem_read_data
//   mem_we/addr/write_data  memory port, muxed from the owner during a beat
//   mem_read_data         synchronous-read memory output
//   busy                  any grant held
module sha_mem_arbiter #(
  parameter int NUM_CORES = 8,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_last,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  output logic [NUM_CORES-1:0]        core_gnt,
  output logic [NUM_CORES-1:0]        core_rvalid,
  output logic [DATA_W-1:0]           core_rdata,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_write_data,
  input  logic [DATA_W-1:0]           mem_read_data,
  output logic                        busy
);
  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_OWN = 1'b1} state_t;

  state_t                 r_state, w_state_nxt;
  logic [IDX_W-1:0]       r_owner;
  logic [7:0]             r_beats;   // beats already completed in this burst
  logic [NUM_CORES-1:0]   r_gnt;
  logic [NUM_CORES-1:0]   r_rvalid;

  logic                   w_beat, w_end, w_arb, w_found;
  logic [IDX_W-1:0]       w_win, w_idx;
  int                     w_start;

  // A beat needs the owner to be requesting; OWN already implies its grant.
  assign w_beat = (r_state == S_OWN) && core_req[r_owner];

  // Burst ends after a last beat, after the MAX_BURST-th beat, or after a
  // granted cycle in which the owner was not requesting.
  assign w_end = (r_state == S_OWN) &&
                 (!core_req[r_owner] || core_last[r_owner] ||
                  (r_beats == 8'(MAX_BURST - 1)));

  assign w_arb = ((r_state == S_IDLE) && (|core_req)) || w_end;

  // Wrapping priority search; the previous owner is checked last.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
`ifdef SHA_ARB_FIXED_PRIO_EN
    w_start = 0;
`else
    w_start = (int'(r_owner) + 1) % NUM_CORES;
`endif
    for (int k = 0; k < NUM_CORES; k++) begin
      w_idx = IDX_W'((w_start + k) % NUM_CORES);
      if (!w_found && core_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_OWN;
      S_OWN:   if (w_end && !w_found) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Owner, grant, beat counter and read-return strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner  <= IDX_W'(NUM_CORES - 1);   // so core 0 wins first
      r_beats  <= '0;
      r_gnt    <= '0;
      r_rvalid <= '0;
    end else begin
      r_rvalid <= '0;
      if (w_beat && !core_we[r_owner]) r_rvalid[r_owner] <= 1'b1;
      if (w_arb) begin
        r_beats <= '0;
        if (w_found) begin
          r_owner <= w_win;
          r_gnt   <= NUM_CORES'(1) << w_win;
        end else begin
          r_gnt   <= '0;
        end
      end else if (w_beat) begin
        r_beats <= r_beats + 8'd1;
      end
    end
  end

  // Outputs: memory port is driven only during a beat, zero otherwise.
  always_comb begin
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    if (w_beat) begin
      mem_we         = core_we[r_owner];
      mem_addr       = core_addr[int'(r_owner)*ADDR_W +: ADDR_W];
      mem_write_data = core_wdata[int'(r_owner)*DATA_W +: DATA_W];
    end
    busy = |r_gnt;
  end

  assign core_gnt    = r_gnt;
  assign core_rvalid = r_rvalid;
  assign core_rdata  = mem_read_data;

endmodule

// File: tb/tb_sha_mem_arbiter.sv
module tb_sha_mem_arbiter;
  localparam int N  = 8;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int MB = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0]    core_req = '0, core_last = '0, core_we = '0;
  logic [N*AW-1:0] core_addr;
  logic [N*DW-1:0] core_wdata;
  logic [N-1:0]    core_gnt, core_rvalid;
  logic [DW-1:0]   core_rdata, mem_write_data;
  logic [DW-1:0]   mem_read_data = '0;
  logic            mem_we, busy;
  logic [AW-1:0]   mem_addr;

  logic [AW-1:0]   a_addr  [N];
  logic [DW-1:0]   a_wdata [N];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always_comb begin
    core_addr  = '0;
    core_wdata = '0;
    for (int i = 0; i < N; i++) begin
      core_addr[i*AW +: AW]  = a_addr[i];
      core_wdata[i*DW +: DW] = a_wdata[i];
    end
  end

  sha_mem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset_n(reset_n),
    .core_req(core_req), .core_last(core_last), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .busy(busy)
  );

  // Synchronous-read memory (256 words, low address byte).
  logic [DW-1:0] mem [256];
  logic          mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | DW'(i);
      mem_ready <= 1'b1;
    end else begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_write_data;
      mem_read_data <= mem[mem_addr[7:0]];
    end
  end

  // ---------------- reference model ----------------
  // Owner as an integer (-1 = nobody), beats counted in plain arithmetic.
  int            m_owner, m_last, m_beats, m_rv;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] ref_mem [256];

  function automatic logic bit_of(input logic [N-1:0] v, input int i);
    return |(v & (N'(1) << i));
  endfunction

  function automatic int pick();
    int start;
`ifdef SHA_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = (m_last + 1) % N;
`endif
    for (int k = 0; k < N; k++)
      if (bit_of(core_req, (start + k) % N)) return (start + k) % N;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_last = N - 1; m_beats = 0; m_rv = -1; m_rdata = '0;
  endtask

  task automatic model_check();
    logic [N-1:0] eg, erv;
    logic beat;
    eg   = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    erv  = (m_rv >= 0) ? (N'(1) << m_rv) : '0;
    beat = (m_owner >= 0) && bit_of(core_req, m_owner);
    chk("gnt",    64'(core_gnt), 64'(eg));
    chk("busy",   64'(busy), 64'(eg != '0));
    chk("mem_we", 64'(mem_we), 64'(beat && bit_of(core_we, m_owner)));
    chk("mem_addr", 64'(mem_addr), beat ? 64'(a_addr[m_owner]) : 64'(0));
    chk("mem_wdata", 64'(mem_write_data), beat ? 64'(a_wdata[m_owner]) : 64'(0));
    chk("rvalid", 64'(core_rvalid), 64'(erv));
    if (m_rv >= 0) chk("rdata", 64'(core_rdata), 64'(m_rdata));
  endtask

  // Advance the model across the coming clock edge using current inputs.
  task automatic model_next();
    logic beat;
    beat = (m_owner >= 0) && bit_of(core_req, m_owner);
    m_rv = -1;
    if (beat && !bit_of(core_we, m_owner)) begin
      m_rv    = m_owner;
      m_rdata = ref_mem[a_addr[m_owner][7:0]];
    end
    if (beat && bit_of(core_we, m_owner)) ref_mem[a_addr[m_owner][7:0]] = a_wdata[m_owner];
    if (m_owner < 0) begin
      if (core_req != '0) begin m_owner = pick(); m_beats = 0; end
    end else begin
      if (beat) m_beats++;
      if (!beat || bit_of(core_last, m_owner) || m_beats == MB) begin
        m_owner = pick(); m_beats = 0;
      end
    end
    if (m_owner >= 0) m_last = m_owner;
  endtask

  // Called at a negedge after inputs are driven; returns at the next negedge.
  task automatic step();
    #1;
    model_check();
    model_next();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    core_req = '0; core_last = '0; core_we = '0;
    for (int i = 0; i < N; i++) begin a_addr[i] = '0; a_wdata[i] = '0; end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_gnt",    64'(core_gnt), 64'(0));
    chk("rst_rvalid", 64'(core_rvalid), 64'(0));
    chk("rst_mem_we", 64'(mem_we), 64'(0));
    chk("rst_addr",   64'(mem_addr), 64'(0));
    chk("rst_busy",   64'(busy), 64'(0));
    model_reset();
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0]  req, last, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [N-1:0]  e_gnt;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [N-1:0]  e_rv;
    logic          e_busy;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [N-1:0] exp_g;
    // core 2 reads 0x10..0x12; held request re-grants once before idling
    tbl[0] = '{8'h04, 8'h00, 8'h00, 16'h10, 32'h0, 8'h00, 1'b0, 16'h00, 32'h0, 8'h00, 1'b0};
    tbl[1] = '{8'h04, 8'h00, 8'h00, 16'h10, 32'h0, 8'h04, 1'b0, 16'h10, 32'h0, 8'h00, 1'b1};
    tbl[2] = '{8'h04, 8'h00, 8'h00, 16'h11, 32'h0, 8'h04, 1'b0, 16'h11, 32'h0, 8'h04, 1'b1};
    tbl[3] = '{8'h04, 8'h04, 8'h00, 16'h12, 32'h0, 8'h04, 1'b0, 16'h12, 32'h0, 8'h04, 1'b1};
    tbl[4] = '{8'h00, 8'h00, 8'h00, 16'h00, 32'h0, 8'h04, 1'b0, 16'h00, 32'h0, 8'h04, 1'b1};
    tbl[5] = '{8'h00, 8'h00, 8'h00, 16'h00, 32'h0, 8'h00, 1'b0, 16'h00, 32'h0, 8'h00, 1'b0};
    // core 3 writes 0xDEADBEEF to 0x20
    tbl[6] = '{8'h08, 8'h08, 8'h08, 16'h20, 32'hDEADBEEF, 8'h00, 1'b0, 16'h00, 32'h0, 8'h00, 1'b0};
    tbl[7] = '{8'h08, 8'h08, 8'h08, 16'h20, 32'hDEADBEEF, 8'h08, 1'b1, 16'h20, 32'hDEADBEEF, 8'h00, 1'b1};
    tbl[8] = '{8'h00, 8'h00, 8'h00, 16'h00, 32'h0, 8'h08, 1'b0, 16'h00, 32'h0, 8'h00, 1'b1};
    tbl[9] = '{8'h00, 8'h00, 8'h00, 16'h00, 32'h0, 8'h00, 1'b0, 16'h00, 32'h0, 8'h00, 1'b0};

    for (int i = 0; i < 256; i++) ref_mem[i] = 32'hA500_0000 | DW'(i);
    clear_inputs();
    apply_reset();

    // ---- table-driven vectors ----
    for (int v = 0; v < 10; v++) begin
      core_req = tbl[v].req; core_last = tbl[v].last; core_we = tbl[v].we;
      for (int i = 0; i < N; i++) begin a_addr[i] = tbl[v].addr; a_wdata[i] = tbl[v].wdata; end
      #1;
      chk($sformatf("tbl%0d_gnt", v),   64'(core_gnt), 64'(tbl[v].e_gnt));
      chk($sformatf("tbl%0d_we", v),    64'(mem_we), 64'(tbl[v].e_we));
      chk($sformatf("tbl%0d_addr", v),  64'(mem_addr), 64'(tbl[v].e_addr));
      chk($sformatf("tbl%0d_wdata", v), 64'(mem_write_data), 64'(tbl[v].e_wdata));
      chk($sformatf("tbl%0d_rv", v),    64'(core_rvalid), 64'(tbl[v].e_rv));
      chk($sformatf("tbl%0d_busy", v),  64'(busy), 64'(tbl[v].e_busy));
      step();
    end

    // ---- cores 0 and 1 together, 2-beat bursts, back to back ----
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      core_req  = (c < 3) ? 8'h03 : 8'h02;
      core_last = (c == 2) ? 8'h01 : ((c == 4) ? 8'h02 : 8'h00);
      a_addr[0] = (c == 2) ? 16'h41 : 16'h40;
      a_addr[1] = (c == 4) ? 16'h51 : 16'h50;
      exp_g = (c == 0) ? 8'h00 : ((c < 3) ? 8'h01 : 8'h02);
      #1;
      chk($sformatf("pair_gnt%0d", c), 64'(core_gnt), 64'(exp_g));
      if (c > 0) chk($sformatf("pair_beat%0d", c), 64'(|(core_gnt & core_req)), 64'(1));
      step();
    end
    clear_inputs();
    repeat (3) step();

    // ---- burst cap: core 5 never lasts, core 6 waiting ----
    apply_reset();
    a_addr[5] = 16'h80; a_addr[6] = 16'h90;
    for (int c = 0; c < 25; c++) begin
      core_req  = (c <= 17) ? 8'h60 : ((c <= 21) ? 8'h20 : 8'h00);
      core_last = 8'h40 | ((c == 21) ? 8'h20 : 8'h00);
      exp_g = (c == 0) ? 8'h00 : (c <= 16) ? 8'h20 : (c == 17) ? 8'h40 :
              (c <= 22) ? 8'h20 : 8'h00;
      #1;
      chk($sformatf("cap_gnt%0d", c), 64'(core_gnt), 64'(exp_g));
      step();
    end

    // ---- cores 1 and 4, repeated 1-beat bursts ----
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      core_req = 8'h12; core_last = 8'h12;
`ifdef SHA_ARB_FIXED_PRIO_EN
      exp_g = (c == 0) ? 8'h00 : 8'h02;
`else
      exp_g = (c == 0) ? 8'h00 : ((c % 2 == 1) ? 8'h02 : 8'h10);
`endif
      #1;
      chk($sformatf("alt_gnt%0d", c), 64'(core_gnt), 64'(exp_g));
      step();
    end
    clear_inputs();
    repeat (3) step();

    // ---- reset mid read burst, then fresh grant to core 0 ----
    apply_reset();
    core_req = 8'h08; a_addr[3] = 16'h30;
    repeat (3) step();
    #1;
    chk("mid_pre_gnt", 64'(core_gnt), 64'(8'h08));
    chk("mid_pre_rv",  64'(core_rvalid), 64'(8'h08));
    #1;
    apply_reset();
    core_req = 8'h09;
    step();
    #1;
    chk("post_rst_gnt", 64'(core_gnt), 64'(8'h01));
    step();
    clear_inputs();
    repeat (3) step();

    // ---- randomized traffic against the model ----
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        a_addr[i]  = AW'($urandom_range(0, 255));
        a_wdata[i] = $urandom;
      end
      core_req  = N'($urandom);
      core_we   = N'($urandom);
      core_last = (c < 750) ? N'($urandom & $urandom)
                            : (($urandom_range(0, 31) == 0) ? N'($urandom) : '0);
      step();
    end
    clear_inputs();
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha_mem_arbiter.md
# sha_mem_arbiter

Shares the single testbench memory port among NUM_CORES parallel SHA-256 cores in the multi-nonce bitcoin hash top level. Each core raises a request, receives a registered one-hot grant, and owns the port for a burst of read or write beats. Read data returns one cycle later with a per-core valid strobe. Ownership rotates round-robin, and a burst-length cap prevents any core from starving the others.

## Interface
Parameters:
- NUM_CORES, 8, number of requesting SHA cores (2..16)
- ADDR_W, 16, memory address width
- DATA_W, 32, memory data width
- MAX_BURST, 16, maximum beats per grant (1..255)

Ports:
- clk  in  1  clock; memory is clocked on the same edge
- reset_n  in  1  asynchronous, active-low reset
- core_req  in  NUM_CORES  per-core request; held high for the whole burst
- core_last  in  NUM_CORES  marks the final beat of the burst
- core_we  in  NUM_CORES  beat is a write (1) or a read (0)
- core_addr  in  NUM_CORES*ADDR_W  packed addresses; core i at [i*ADDR_W +: ADDR_W]
- core_wdata  in  NUM_CORES*DATA_W  packed write data
- core_gnt  out  NUM_CORES  registered one-hot grant
- core_rvalid  out  NUM_CORES  read data valid for the core that issued the read one cycle earlier
- core_rdata  out  DATA_W  broadcast of mem_read_data
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_write_data  out  DATA_W  memory write data
- mem_read_data  in  DATA_W  synchronous-read memory output; valid one cycle after address
- busy  out  1  high while any grant is held

## Operation
- States:
  - IDLE: no grant.
  - OWN: exactly one core_gnt bit is set. An owner register and a beat counter (8 bit) are kept.
- Beat definition: a beat occurs in any cycle where core_gnt[i] & core_req[i].
  - mem_addr, mem_we and mem_write_data are a combinational mux of the owner's signals.
  - mem_we = core_we[owner] & core_req[owner].
  - Outside a beat, mem_we=0, mem_addr=0 and mem_write_data=0.
- IDLE -> OWN: at the first edge where core_req is nonzero, the winner is registered into core_gnt. The beat counter is cleared.
- End of burst: the owner's burst ends at the edge following any of these:
  - a beat with core_last=1;
  - the MAX_BURST-th beat;
  - a cycle in OWN with core_req[owner]=0 (no beat that cycle).
- Re-arbitration at that same edge, with no bubble cycle:
  - The search starts at (owner+1) mod NUM_CORES.
  - If another core requests, it is granted directly (OWN -> OWN) and the counter is cleared.
  - If only the previous owner requests, it is granted again.
  - If nobody requests, the block goes to IDLE.
- Read return: core_rvalid[i] is registered high for one cycle after each read beat by core i. core_rdata always equals mem_read_data.
- The arbiter never issues a beat for a core that is not granted. Cores must not change core_addr or core_we mid-beat.
- busy = |core_gnt.

## Timing
- Reset values: core_gnt=0, core_rvalid=0, busy=0, mem_we=0, mem_addr=0, mem_write_data=0. The owner pointer resets to NUM_CORES-1, so core 0 wins first.
- Request-to-grant latency: 1 cycle from IDLE. Grant-to-first-beat latency: 0 cycles.
- Read latency: address in cycle N, then core_rvalid and core_rdata in cycle N+1.
- A burst of B beats occupies B cycles. The next owner's first beat happens in the next cycle.
- Simultaneous requests while idle: the round-robin winner is granted and the others wait. Requests are never dropped and no acknowledge is needed.
- A core dropping core_req and raising it again while another core owns the port only waits for its rotation turn.
- Reset mid-burst: the grant and any pending core_rvalid are cleared asynchronously. The burst is not resumed after reset.

## Configuration
- SHA_ARB_FIXED_PRIO_EN:
  - Defined: the arbitration search always starts at core 0, so the lowest requesting index wins. The owner pointer is unused and MAX_BURST still applies.
  - Undefined (default): round-robin search from owner+1 as described under Operation.

## Test plan
- Core 2 alone reads 3 beats (addr 0x10..0x12, last on beat 3):
  - Expect core_gnt=0x04 one cycle after core_req.
  - Expect mem_addr 0x10, 0x11, 0x12 on consecutive cycles.
  - Expect core_rvalid[2] for 3 cycles, delayed one cycle, and busy to fall after the burst.
- Cores 0 and 1 request together from reset, 2-beat bursts each:
  - Expect core 0 to be granted, then core 1 with no idle cycle, for 4 consecutive beats.
- Core 5 holds core_req for 20 beats and never asserts last, while core 6 also requests:
  - Expect the grant to move to core 6 after exactly 16 beats.
  - Expect core 5 to regain the grant after core 6 finishes.
- Core 3 writes 0xDEADBEEF to 0x20:
  - Expect mem_we=1, mem_addr=0x20 and mem_write_data=0xDEADBEEF in the grant cycle, and no core_rvalid.
- With SHA_ARB_FIXED_PRIO_EN, cores 1 and 4 repeatedly request 1-beat bursts:
  - Expect core 1 to win every arbitration.
  - Without the macro, expect the grants to alternate 1, 4, 1, 4.
- reset_n pulsed low mid-read-burst:
  - Expect core_gnt, core_rvalid and mem_we to go to 0 immediately.
  - After release, expect a fresh grant to core 0 if it requests.
